// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, move_signal bit indices and screen dimensions.
package game_pkg;
    typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;
    localparam int MV_RIGHT  = 0;
    localparam int MV_LEFT   = 1;
    localparam int MV_JPRESS = 2;
    localparam int MV_JHELD  = 3;
    localparam int SCR_W     = 640;
    localparam int PLR_W     = 16;
    localparam int PLR_H     = 16;
    localparam int FLR_Y     = 400;
endpackage

// File: rtl/clamp_s11.sv
// clamp_s11: clamps a signed 11-bit value into [lo, hi].
module clamp_s11 (
    input  logic signed [10:0] val,
    input  logic signed [10:0] lo,
    input  logic signed [10:0] hi,
    output logic signed [10:0] res
);
    assign res = val < lo ? lo : val > hi ? hi : val;
endmodule

// File: rtl/player_motion.sv
// player_motion: per-frame player position update with walking, gravity,
// double jump, variable jump height and screen/floor clamping.
module player_motion
    import game_pkg::*;
#(
    parameter int SCREEN_W = SCR_W,
    parameter int PLAYER_W = PLR_W,
    parameter int PLAYER_H = PLR_H,
    parameter int FLOOR_Y  = FLR_Y,
    parameter int X_START  = 100,
    parameter int WALK     = 3,
    parameter int JUMP_V   = -8,
    parameter int DJUMP_V  = -7,
    parameter int GRAV     = 1,
    parameter int MAX_FALL = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic [3:0]        move_signal,
    output logic [9:0]        x_pos,
    output logic [8:0]        y_pos,
    output logic signed [4:0] vy,
    output logic              on_ground,
    output logic [1:0]        jumps_left
);
    localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - PLAYER_W);
    localparam logic signed [10:0] Y_MAX = 11'(FLOOR_Y - PLAYER_H);
    localparam logic signed [4:0]  V_MAX = 5'(MAX_FALL);

    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic signed [4:0] vy_q, vy_d;
    state_t            state_q, state_d;
    logic [1:0]        jumps_q, jumps_d;
    logic              pend_q, pend_d;
    logic              held_q, held_d;

    logic              right, left, jump, cut;
    logic signed [10:0] x_step, x_raw, x_cl, vy_ext, y_next, y_cl;
    logic signed [4:0] vy_inc, vy_new;
    logic              unused_cl;

    assign right  = move_signal[MV_RIGHT] & ~move_signal[MV_LEFT];
    assign left   = move_signal[MV_LEFT] & ~move_signal[MV_RIGHT];
    assign x_step = right ? 11'(WALK) : left ? 11'(-WALK) : '0;
    assign x_raw  = $signed({1'b0, x_q}) + x_step;

    // a press landing on the tick cycle itself is consumed by that tick
    assign jump   = (pend_q | move_signal[MV_JPRESS]) && jumps_q != 2'd0;
    assign cut    = !jump && held_q && !move_signal[MV_JHELD] && vy_q < 0;
    assign vy_inc = vy_q + 5'(GRAV);
    assign vy_new = jump ? (state_q == GROUND ? 5'(JUMP_V) : 5'(DJUMP_V)) :
                    cut ? vy_q >>> 1 :
                    state_q != GROUND ? (vy_inc > V_MAX ? V_MAX : vy_inc) : vy_q;
    assign vy_ext = {{6{vy_new[4]}}, vy_new};
    assign y_next = $signed({2'b0, y_q}) + vy_ext;

    clamp_s11 u_clamp_x (.val(x_raw),  .lo(11'sd0), .hi(X_MAX), .res(x_cl));
    clamp_s11 u_clamp_y (.val(y_next), .lo(11'sd0), .hi(Y_MAX), .res(y_cl));

    assign unused_cl = ^{x_cl[10], y_cl[10:9]};

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        vy_d    = vy_q;
        state_d = state_q;
        jumps_d = jumps_q;
        held_d  = held_q;
        pend_d  = pend_q | move_signal[MV_JPRESS];
        if (frame_tick) begin
            pend_d  = 1'b0;
            held_d  = move_signal[MV_JHELD];
            x_d     = x_cl[9:0];
            y_d     = y_cl[8:0];
            vy_d    = vy_new;
            jumps_d = jump ? jumps_q - 2'd1 : jumps_q;
            state_d = vy_new < 0 ? RISE : FALL;
            if (y_next >= Y_MAX) begin
                vy_d    = '0;
                state_d = GROUND;
                jumps_d = 2'd2;
            end else if (y_next < 0) begin
                vy_d    = '0;
                state_d = FALL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= 10'(X_START);
            y_q     <= 9'(FLOOR_Y - PLAYER_H);
            vy_q    <= '0;
            state_q <= GROUND;
            jumps_q <= 2'd2;
            pend_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            state_q <= state_d;
            jumps_q <= jumps_d;
            pend_q  <= pend_d;
            held_q  <= held_d;
        end
    end

    assign x_pos      = x_q;
    assign y_pos      = y_q;
    assign vy         = vy_q;
    assign on_ground  = state_q == GROUND;
    assign jumps_left = jumps_q;
endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: directed-vector bench for player_motion.
module tb_player_motion;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_tick = 1'b0;
    logic [3:0]        move_signal = 4'b0000;
    logic [9:0]        x_pos;
    logic [8:0]        y_pos;
    logic signed [4:0] vy;
    logic              on_ground;
    logic [1:0]        jumps_left;

    int vectors = 0;
    int miscompares = 0;

    player_motion dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .move_signal(move_signal),
        .x_pos(x_pos), .y_pos(y_pos), .vy(vy), .on_ground(on_ground), .jumps_left(jumps_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [3:0] m);
        @(negedge clk);
        move_signal = m;
        frame_tick  = 1'b1;
        @(negedge clk);
        frame_tick  = 1'b0;
        move_signal = m & 4'b1011;
    endtask

    task automatic press();
        @(negedge clk);
        move_signal[2] = 1'b1;
        @(negedge clk);
        move_signal[2] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic land(input logic [3:0] m, input string tag);
        for (int i = 0; i < 40 && !on_ground; i++) tick(m);
        chk(tag, int'(on_ground), 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_x", int'(x_pos), 100);
        chk("rst_y", int'(y_pos), 384);
        chk("rst_vy", int'(vy), 0);
        chk("rst_og", int'(on_ground), 1);
        chk("rst_jl", int'(jumps_left), 2);

        for (int i = 0; i < 10; i++) begin
            tick(4'b0001);
            chk("walk_y", int'(y_pos), 384);
            chk("walk_og", int'(on_ground), 1);
        end
        chk("walk_x", int'(x_pos), 130);

        press();
        press();
        for (int t = 1; t <= 17; t++) begin
            tick(4'b1000);
            if (t == 1) begin
                chk("j1_vy", int'(vy), -8);
                chk("j1_y", int'(y_pos), 376);
                chk("j1_jl", int'(jumps_left), 1);
                repeat (3) @(negedge clk);
                chk("hold_y", int'(y_pos), 376);
            end
            if (t == 2) chk("j2_vy", int'(vy), -7);
            if (t == 9) begin
                chk("j9_vy", int'(vy), 0);
                chk("j9_y", int'(y_pos), 348);
                chk("j9_og", int'(on_ground), 0);
            end
        end
        chk("j17_y", int'(y_pos), 384);
        chk("j17_vy", int'(vy), 0);
        chk("j17_og", int'(on_ground), 1);
        chk("j17_jl", int'(jumps_left), 2);
        chk("j_x", int'(x_pos), 130);

        press();
        repeat (3) tick(4'b1000);
        chk("dj3_vy", int'(vy), -6);
        chk("dj3_y", int'(y_pos), 363);
        press();
        tick(4'b1000);
        chk("dj4_vy", int'(vy), -7);
        chk("dj4_y", int'(y_pos), 356);
        chk("dj4_jl", int'(jumps_left), 0);
        press();
        tick(4'b1000);
        chk("dj5_vy", int'(vy), -6);
        chk("dj5_y", int'(y_pos), 350);
        chk("dj5_jl", int'(jumps_left), 0);
        land(4'b1000, "dj_land");

        tick(4'b1100);
        chk("rc1_vy", int'(vy), -8);
        chk("rc1_y", int'(y_pos), 376);
        tick(4'b0000);
        chk("rc2_vy", int'(vy), -4);
        chk("rc2_y", int'(y_pos), 372);
        tick(4'b0000);
        chk("rc3_vy", int'(vy), -3);
        chk("rc3_y", int'(y_pos), 369);
        land(4'b0000, "rc_land");

        do_reset();
        repeat (33) tick(4'b0010);
        chk("xl_1", int'(x_pos), 1);
        tick(4'b0010);
        chk("xl_0", int'(x_pos), 0);
        tick(4'b0010);
        chk("xl_00", int'(x_pos), 0);
        do_reset();
        repeat (174) tick(4'b0001);
        chk("xr_622", int'(x_pos), 622);
        tick(4'b0001);
        chk("xr_624", int'(x_pos), 624);
        tick(4'b0011);
        chk("xb_624", int'(x_pos), 624);
        tick(4'b0010);
        tick(4'b0011);
        chk("xb_621", int'(x_pos), 621);

        tick(4'b1100);
        repeat (3) tick(4'b1000);
        chk("mr_y", int'(y_pos), 358);
        chk("mr_vy", int'(vy), -5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_y", int'(y_pos), 384);
        chk("ar_x", int'(x_pos), 100);
        chk("ar_vy", int'(vy), 0);
        chk("ar_jl", int'(jumps_left), 2);
        chk("ar_og", int'(on_ground), 1);
        @(negedge clk);
        rst = 1'b0;
        tick(4'b0000);
        chk("pr_y", int'(y_pos), 384);
        chk("pr_og", int'(on_ground), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
